// File: rtl/fifo_flush_wr_ctrl_if.sv
// Write-side bundle between producers, the flush controller and the FIFO.
// Optional feature macro: none (see fifo_flush_wr_ctrl.sv for FIFO_FLUSH_STATS_EN).
// Signals:
//   req_valid_i     per-requester write request
//   req_data_i      requester i data at [i*DATA_W +: DATA_W]
//   req_ready_o     one-hot grant, combinational
//   fifo_full_i     FIFO full flag
//   fifo_empty_i    FIFO empty flag
//   fifo_wr_valid_o FIFO write strobe
//   fifo_wr_data_o  FIFO write data
// Modports: master = producer/FIFO side, slave = controller side.
interface fifo_flush_wr_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      fifo_full_i;
  logic                      fifo_empty_i;
  logic                      fifo_wr_valid_o;
  logic [DATA_W-1:0]         fifo_wr_data_o;

  modport master (
    output req_valid_i, req_data_i, fifo_full_i, fifo_empty_i,
    input  req_ready_o, fifo_wr_valid_o, fifo_wr_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, fifo_full_i, fifo_empty_i,
    output req_ready_o, fifo_wr_valid_o, fifo_wr_data_o
  );
endinterface

// File: rtl/fifo_flush_wr_ctrl.sv
// Write-side controller for a flushable FIFO: round-robin arbitration of
// NUM_REQ writers onto one write port, plus a flush sequencer
// (IDLE -> [DRAIN] -> FLUSH -> DONE -> IDLE).
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-low
//   bus           write bundle (slave modport), see fifo_flush_wr_ctrl_if
//   flush_req_i   flush request, sampled in IDLE only
//   drain_i       1 = drain before flush, 0 = immediate flush
//   fifo_flush_o  registered FIFO flush, high FLUSH_HOLD cycles
//   flush_busy_o  high outside IDLE
//   flush_done_o  one-cycle pulse on flush completion
// Optional feature: define FIFO_FLUSH_STATS_EN to add
//   flush_cnt_o [7:0] saturating count of completed flushes
//   timeout_o   [0:0] sticky flag, set on a timed-out drain
module fifo_flush_wr_ctrl #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned FLUSH_HOLD    = 2,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  fifo_flush_wr_ctrl_if.slave       bus,
  input  logic                      flush_req_i,
  input  logic                      drain_i,
  output logic                      fifo_flush_o,
  output logic                      flush_busy_o,
  output logic                      flush_done_o
`ifdef FIFO_FLUSH_STATS_EN
  ,
  output logic [7:0]                flush_cnt_o,
  output logic [0:0]                timeout_o
`endif
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TO_W   = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]    NUM_EXT  = (PTR_W+1)'(NUM_REQ);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLUSH_HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic               flush_nxt, done_nxt, forced_exit;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     scan;
  logic [NUM_REQ-1:0] ready_c;
  logic [DATA_W-1:0]  wr_data_c;
  logic               wr_accept;

  // Round-robin search starting at rr_ptr; only IDLE with room in the FIFO grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    if (state == IDLE && !bus.fifo_full_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (scan >= NUM_EXT) scan = scan - NUM_EXT;
        if (!grant_found && bus.req_valid_i[scan[PTR_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = scan[PTR_W-1:0];
        end
      end
    end
  end

  // One-hot grant and write-data mux.
  always_comb begin
    ready_c   = '0;
    wr_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_found && grant_idx == PTR_W'(i)) begin
        ready_c[i] = 1'b1;
        wr_data_c  = bus.req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_accept           = |(bus.req_valid_i & ready_c);
  assign bus.req_ready_o     = ready_c;
  assign bus.fifo_wr_valid_o = wr_accept;
  assign bus.fifo_wr_data_o  = wr_data_c;

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    to_cnt_nxt   = to_cnt;
    hold_cnt_nxt = hold_cnt;
    forced_exit  = 1'b0;

    if (wr_accept) rr_ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

    case (state)
      IDLE: begin
        if (flush_req_i) begin
          if (drain_i) begin
            state_nxt  = DRAIN;
            to_cnt_nxt = '0;
          end else begin
            state_nxt    = FLUSH;
            hold_cnt_nxt = '0;
          end
        end
      end
      DRAIN: begin
        // Empty takes priority over the timeout in the same cycle.
        if (bus.fifo_empty_i) begin
          state_nxt    = FLUSH;
          hold_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          state_nxt    = FLUSH;
          hold_cnt_nxt = '0;
          forced_exit  = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      FLUSH: begin
        if (hold_cnt == HOLD_LAST) state_nxt = DONE;
        else                       hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    flush_nxt = (state_nxt == FLUSH);
    done_nxt  = (state_nxt == DONE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      to_cnt       <= '0;
      hold_cnt     <= '0;
      fifo_flush_o <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      to_cnt       <= to_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      fifo_flush_o <= flush_nxt;
      flush_done_o <= done_nxt;
    end
  end

  assign flush_busy_o = (state != IDLE);

`ifdef FIFO_FLUSH_STATS_EN
  // Completed-flush counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flush_cnt_o <= '0;
      timeout_o   <= '0;
    end else begin
      if (done_nxt && flush_cnt_o != 8'hFF) flush_cnt_o <= flush_cnt_o + 8'd1;
      if (forced_exit)                      timeout_o   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flush_wr_ctrl.sv
// Self-checking bench for fifo_flush_wr_ctrl with a behavioural reference model.
module tb_fifo_flush_wr_ctrl;
  localparam int unsigned NUM_REQ       = 4;
  localparam int unsigned DATA_W        = 4;
  localparam int unsigned FLUSH_HOLD    = 2;
  localparam int unsigned DRAIN_TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset;
  logic flush_req_i, drain_i;
  logic fifo_flush_o, flush_busy_o, flush_done_o;
`ifdef FIFO_FLUSH_STATS_EN
  logic [7:0] flush_cnt_o;
  logic [0:0] timeout_o;
`endif

  fifo_flush_wr_ctrl_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_flush_wr_ctrl #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
    .FLUSH_HOLD(FLUSH_HOLD), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .flush_req_i(flush_req_i), .drain_i(drain_i),
    .fifo_flush_o(fifo_flush_o), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o)
`ifdef FIFO_FLUSH_STATS_EN
    , .flush_cnt_o(flush_cnt_o), .timeout_o(timeout_o)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rr = 0;
  int m_flush_cnt = 0;
  bit m_timeout = 1'b0;

  // Expected grant index from the round-robin rule, -1 when nothing is granted.
  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input logic full);
    if (full) return -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int g);
    logic [NUM_REQ*DATA_W-1:0] d;
    d = bus.req_data_i;
    if (g < 0) return '0;
    return d[g*DATA_W +: DATA_W];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    if (g < 0) return '0;
    return NUM_REQ'(1) << g;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle_inputs();
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.fifo_full_i  = 1'b0;
    bus.fifo_empty_i = 1'b0;
    flush_req_i      = 1'b0;
    drain_i          = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    m_rr = 0;
    m_flush_cnt = 0;
    m_timeout = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b0;
    set_idle_inputs();
    bus.req_valid_i = '1;
    flush_req_i = 1'b1;
    tick();
    tick();
    @(negedge clock);
    checks++;
    if (flush_busy_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b flush=%b done=%b required 0 0 0", flush_busy_o, fifo_flush_o, flush_done_o);
    end
    tick();
    reset = 1'b1;
    flush_req_i = 1'b0;
    m_rr = 0; m_flush_cnt = 0; m_timeout = 1'b0;
    bus.req_data_i = 16'hA5C3;
    @(negedge clock);
    g = exp_grant(bus.req_valid_i, bus.fifo_full_i);
    checks++;
    if (bus.req_ready_o !== 4'b0001 || bus.fifo_wr_data_o !== 4'h3 || flush_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b data=%h busy=%b required 0001 3 0", bus.req_ready_o, bus.fifo_wr_data_o, flush_busy_o);
    end
`ifdef FIFO_FLUSH_STATS_EN
    checks++;
    if (flush_cnt_o !== 8'd0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats: cnt=%0d to=%b required 0 0", flush_cnt_o, timeout_o);
    end
`endif
    if (g >= 0) m_rr = (g + 1) % NUM_REQ;
    tick();
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    bus.req_valid_i = '1;
    for (int c = 0; c < 8; c++) begin
      bus.req_data_i = 16'($urandom);
      @(negedge clock);
      g = exp_grant(bus.req_valid_i, bus.fifo_full_i);
      checks++;
      if (bus.req_ready_o !== onehot(c % 4) || bus.fifo_wr_valid_o !== 1'b1 ||
          bus.fifo_wr_data_o !== exp_data(c % 4)) begin
        errors++;
        $display("FAIL rr_all_valid[%0d]: ready=%b data=%h required %b %h", c, bus.req_ready_o,
                 bus.fifo_wr_data_o, onehot(c % 4), exp_data(c % 4));
      end
      if (g >= 0) m_rr = (g + 1) % NUM_REQ;
      tick();
    end
  endtask

  task automatic test_sparse_full();
    int exp_seq[4] = '{1, 3, 1, 3};
    do_reset();
    bus.req_valid_i = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      bus.req_data_i  = 16'($urandom);
      bus.fifo_full_i = (c == 3 || c == 4);
    end
    for (int c = 0; c < 6; c++) begin
      int exp_g;
      bus.req_data_i  = 16'($urandom);
      bus.fifo_full_i = (c == 3 || c == 4);
      exp_g = (c < 3) ? exp_seq[c] : (c == 5 ? exp_seq[3] : -1);
      @(negedge clock);
      checks++;
      if (bus.req_ready_o !== onehot(exp_g) || bus.fifo_wr_valid_o !== (exp_g >= 0) ||
          bus.fifo_wr_data_o !== exp_data(exp_g)) begin
        errors++;
        $display("FAIL sparse_full[%0d]: ready=%b wr=%b data=%h required %b %b %h", c, bus.req_ready_o,
                 bus.fifo_wr_valid_o, bus.fifo_wr_data_o, onehot(exp_g), exp_g >= 0, exp_data(exp_g));
      end
      if (exp_g >= 0) m_rr = (exp_g + 1) % NUM_REQ;
      tick();
    end
    bus.fifo_full_i = 1'b0;
  endtask

  task automatic test_random_arb();
    int g;
    for (int c = 0; c < 300; c++) begin
      bus.req_valid_i = 4'($urandom);
      bus.req_data_i  = 16'($urandom);
      bus.fifo_full_i = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      g = exp_grant(bus.req_valid_i, bus.fifo_full_i);
      checks++;
      if (bus.req_ready_o !== onehot(g) || bus.fifo_wr_valid_o !== (g >= 0) ||
          bus.fifo_wr_data_o !== exp_data(g) || flush_busy_o !== 1'b0) begin
        errors++;
        $display("FAIL random_arb[%0d]: ready=%b wr=%b data=%h busy=%b required %b %b %h 0", c,
                 bus.req_ready_o, bus.fifo_wr_valid_o, bus.fifo_wr_data_o, flush_busy_o,
                 onehot(g), g >= 0, exp_data(g));
      end
      if (g >= 0) m_rr = (g + 1) % NUM_REQ;
      tick();
    end
    set_idle_inputs();
  endtask

  // graceful=0: immediate flush. empty_at=0: FIFO never empties; else empty in that DRAIN cycle.
  task automatic test_flush(input bit graceful, input int empty_at);
    int g, drain_len;
    bit forced;
    forced    = graceful && (empty_at == 0 || empty_at > int'(DRAIN_TIMEOUT));
    drain_len = !graceful ? 0 : (forced ? int'(DRAIN_TIMEOUT) : empty_at);

    bus.req_valid_i  = '1;
    bus.req_data_i   = 16'($urandom);
    bus.fifo_full_i  = 1'b0;
    bus.fifo_empty_i = 1'b0;
    flush_req_i      = 1'b1;
    drain_i          = graceful;
    @(negedge clock);
    g = exp_grant(bus.req_valid_i, bus.fifo_full_i);
    checks++;
    if (bus.req_ready_o !== onehot(g) || flush_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_trigger_write: ready=%b busy=%b required %b 0", bus.req_ready_o, flush_busy_o, onehot(g));
    end
    if (g >= 0) m_rr = (g + 1) % NUM_REQ;
    tick();

    for (int d = 1; d <= drain_len; d++) begin
      bus.fifo_empty_i = (empty_at != 0 && d >= empty_at);
      flush_req_i = 1'($urandom);
      @(negedge clock);
      checks++;
      if (flush_busy_o !== 1'b1 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b0 ||
          bus.req_ready_o !== '0 || bus.fifo_wr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: busy=%b flush=%b done=%b ready=%b required 1 0 0 0000", d,
                 flush_busy_o, fifo_flush_o, flush_done_o, bus.req_ready_o);
      end
      tick();
    end
    if (forced) m_timeout = 1'b1;

    bus.fifo_empty_i = 1'b0;
    for (int h = 1; h <= int'(FLUSH_HOLD); h++) begin
      flush_req_i = 1'b1;
      @(negedge clock);
      checks++;
      if (flush_busy_o !== 1'b1 || fifo_flush_o !== 1'b1 || flush_done_o !== 1'b0 ||
          bus.req_ready_o !== '0) begin
        errors++;
        $display("FAIL flush_hold[%0d]: busy=%b flush=%b done=%b ready=%b required 1 1 0 0000", h,
                 flush_busy_o, fifo_flush_o, flush_done_o, bus.req_ready_o);
      end
      tick();
    end

    @(negedge clock);
    if (m_flush_cnt < 255) m_flush_cnt++;
    checks++;
    if (flush_busy_o !== 1'b1 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b1 || bus.req_ready_o !== '0) begin
      errors++;
      $display("FAIL flush_done: busy=%b flush=%b done=%b ready=%b required 1 0 1 0000",
               flush_busy_o, fifo_flush_o, flush_done_o, bus.req_ready_o);
    end
    tick();

    flush_req_i = 1'b0;
    @(negedge clock);
    g = exp_grant(bus.req_valid_i, bus.fifo_full_i);
    checks++;
    if (flush_busy_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b0 || bus.req_ready_o !== onehot(g)) begin
      errors++;
      $display("FAIL flush_back_idle: busy=%b flush=%b done=%b ready=%b required 0 0 0 %b",
               flush_busy_o, fifo_flush_o, flush_done_o, bus.req_ready_o, onehot(g));
    end
`ifdef FIFO_FLUSH_STATS_EN
    checks++;
    if (flush_cnt_o !== 8'(m_flush_cnt) || timeout_o !== m_timeout) begin
      errors++;
      $display("FAIL flush_stats: cnt=%0d to=%b required %0d %b", flush_cnt_o, timeout_o, m_flush_cnt, m_timeout);
    end
`endif
    if (g >= 0) m_rr = (g + 1) % NUM_REQ;
    tick();
    set_idle_inputs();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    bus.req_valid_i = 4'b0001;
    bus.req_data_i  = 16'($urandom);
    @(negedge clock);
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_pre_write: ready=%b required 0001", bus.req_ready_o);
    end
    m_rr = 1;
    tick();
    bus.req_valid_i = '0;
    flush_req_i = 1'b1;
    drain_i = 1'b0;
    tick();
    reset = 1'b0;
    flush_req_i = 1'b0;
    @(negedge clock);
    checks++;
    if (fifo_flush_o !== 1'b1 || flush_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_flush: flush=%b busy=%b required 1 1", fifo_flush_o, flush_busy_o);
    end
    tick();
    reset = 1'b1;
    m_rr = 0; m_flush_cnt = 0; m_timeout = 1'b0;
    bus.req_valid_i = '1;
    @(negedge clock);
    checks++;
    if (flush_busy_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b0 || bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_after: busy=%b flush=%b done=%b ready=%b required 0 0 0 0001",
               flush_busy_o, fifo_flush_o, flush_done_o, bus.req_ready_o);
    end
    m_rr = 1;
    tick();
    bus.req_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (flush_done_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_busy_o !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_done[%0d]: done=%b flush=%b busy=%b required 0 0 0", c,
                 flush_done_o, fifo_flush_o, flush_busy_o);
      end
      tick();
    end
`ifdef FIFO_FLUSH_STATS_EN
    checks++;
    if (flush_cnt_o !== 8'd0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stats: cnt=%0d to=%b required 0 0", flush_cnt_o, timeout_o);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    set_idle_inputs();
    test_reset();
    test_round_robin();
    test_sparse_full();
    test_random_arb();
    test_flush(1'b0, 0);
    test_flush(1'b1, 5);
    test_flush(1'b1, 1);
    test_flush(1'b1, 16);
    test_flush(1'b1, 0);
    for (int r = 0; r < 4; r++) test_flush(1'b1, $urandom_range(1, 16));
    test_flush(1'b0, 0);
    test_random_arb();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
